// File: rtl/alu_cmd_sequencer.sv
// Command/response sequencer in front of the 8-bit combinational ALU.
// Registers ALU inputs, captures its outputs one cycle later, qualifies flags and keeps status.
module alu_cmd_sequencer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [3:0]  cmd_sel_i,
    input  logic [7:0]  cmd_a_i,
    input  logic [7:0]  cmd_b_i,
    output logic [7:0]  alu_a_o,
    output logic [7:0]  alu_b_o,
    output logic [3:0]  alu_sel_o,
    input  logic [7:0]  alu_result_i,
    input  logic        alu_carry_i,
    input  logic        alu_zero_i,
    input  logic        alu_negative_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [7:0]  rsp_result_o,
    output logic [3:0]  rsp_flags_o,
    output logic [3:0]  sticky_flags_o,
    input  logic        clr_sticky_i,
    output logic [15:0] op_count_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t      state_q;
    logic        cmd_ready_q;
    logic [7:0]  alu_a_q;
    logic [7:0]  alu_b_q;
    logic [3:0]  alu_sel_q;
    logic        rsp_valid_q;
    logic [7:0]  rsp_result_q;
    logic [3:0]  rsp_flags_q;
    logic [3:0]  sticky_q;
    logic [15:0] op_count_q;

    logic [3:0]  flags_d;
    logic [3:0]  sticky_base_d;

    // Signed overflow only exists for ADD and SUB; all other opcodes report none.
    function automatic logic calc_overflow(input logic [3:0] sel,
                                           input logic [7:0] a,
                                           input logic [7:0] b,
                                           input logic [7:0] r);
        logic ovf;
        case (sel)
            4'b0000: ovf = (a[7] == b[7]) && (r[7] != a[7]);
            4'b0001: ovf = (a[7] != b[7]) && (r[7] != a[7]);
            default: ovf = 1'b0;
        endcase
        return ovf;
    endfunction

    // Qualified flags for the capture; a clear in the capture cycle drops the old sticky value only.
    always_comb begin
        flags_d = {calc_overflow(alu_sel_q, alu_a_q, alu_b_q, alu_result_i),
                   alu_negative_i,
                   alu_zero_i,
                   alu_carry_i & (alu_sel_q[3:2] == 2'b00)};
        sticky_base_d = clr_sticky_i ? 4'b0000 : sticky_q;
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            cmd_ready_q  <= 1'b1;
            alu_a_q      <= 8'h00;
            alu_b_q      <= 8'h00;
            alu_sel_q    <= 4'b0000;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= 8'h00;
            rsp_flags_q  <= 4'b0000;
            sticky_q     <= 4'b0000;
            op_count_q   <= 16'h0000;
        end else begin
            if (clr_sticky_i) begin
                sticky_q <= 4'b0000;
            end
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid_i) begin
                        alu_a_q     <= cmd_a_i;
                        alu_b_q     <= cmd_b_i;
                        alu_sel_q   <= cmd_sel_i;
                        cmd_ready_q <= 1'b0;
                        state_q     <= ST_ISSUE;
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    rsp_result_q <= alu_result_i;
                    rsp_flags_q  <= flags_d;
                    sticky_q     <= sticky_base_d | flags_d;
                    rsp_valid_q  <= 1'b1;
                    state_q      <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        op_count_q  <= op_count_q + 16'd1;
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o    = cmd_ready_q;
    assign alu_a_o        = alu_a_q;
    assign alu_b_o        = alu_b_q;
    assign alu_sel_o      = alu_sel_q;
    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_result_o   = rsp_result_q;
    assign rsp_flags_o    = rsp_flags_q;
    assign sticky_flags_o = sticky_q;
    assign op_count_o     = op_count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: behavioural ALU, scoreboard of expected
// {result, flags} pushed at command acceptance and popped at the response handshake.
module tb_alu_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_sel = 4'h0;
    logic [7:0]  cmd_a = 8'h00;
    logic [7:0]  cmd_b = 8'h00;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [3:0]  alu_sel;
    logic [7:0]  alu_result;
    logic        alu_carry;
    logic        alu_zero;
    logic        alu_negative;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [7:0]  rsp_result;
    logic [3:0]  rsp_flags;
    logic [3:0]  sticky_flags;
    logic        clr_sticky = 1'b0;
    logic [15:0] op_count;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [11:0] sb_q[$];
    logic [3:0]  exp_sticky = 4'h0;
    logic [15:0] exp_count = 16'h0;

    always #5 clk = ~clk;

    alu_cmd_sequencer dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_sel_i(cmd_sel), .cmd_a_i(cmd_a), .cmd_b_i(cmd_b),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_sel_o(alu_sel),
        .alu_result_i(alu_result), .alu_carry_i(alu_carry),
        .alu_zero_i(alu_zero), .alu_negative_i(alu_negative),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_result_o(rsp_result), .rsp_flags_o(rsp_flags),
        .sticky_flags_o(sticky_flags), .clr_sticky_i(clr_sticky),
        .op_count_o(op_count)
    );

    // Behavioural ALU; logic ops drive a junk carry of 1 so masking is observable.
    always_comb begin
        logic [8:0] t;
        t = 9'h000;
        alu_carry = 1'b1;
        case (alu_sel)
            4'b0000: begin t = {1'b0, alu_a} + {1'b0, alu_b}; alu_carry = t[8]; end
            4'b0001: begin t = {1'b0, alu_a} - {1'b0, alu_b}; alu_carry = t[8]; end
            4'b0100: t = {1'b0, alu_a & alu_b};
            4'b0101: t = {1'b0, alu_a | alu_b};
            4'b0110: t = {1'b0, alu_a ^ alu_b};
            default: t = {1'b0, alu_a};
        endcase
        alu_result   = t[7:0];
        alu_zero     = (t[7:0] == 8'h00);
        alu_negative = t[7];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: returns {result, ovf, neg, zero, carry} from integer arithmetic.
    function automatic logic [11:0] model(input logic [3:0] sel, input logic [7:0] a, input logic [7:0] b);
        int s;
        int sv;
        logic [7:0] r;
        logic c;
        logic v;
        c = 1'b0;
        v = 1'b0;
        case (sel)
            4'b0000: begin
                s = int'(a) + int'(b);
                sv = int'($signed(a)) + int'($signed(b));
                c = (s > 255);
                v = (sv > 127) || (sv < -128);
                r = s[7:0];
            end
            4'b0001: begin
                s = int'(a) - int'(b);
                sv = int'($signed(a)) - int'($signed(b));
                c = (s < 0);
                v = (sv > 127) || (sv < -128);
                r = s[7:0];
            end
            4'b0100: r = a & b;
            4'b0101: r = a | b;
            4'b0110: r = a ^ b;
            default: r = a;
        endcase
        return {r, v, r[7], (r == 8'h00), c};
    endfunction

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1 rst = 1'b0;
        exp_sticky = 4'h0;
        exp_count = 16'h0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        if (n >= 20) check("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
    endtask

    // One full transaction: accept, issue (optional clear), respond after 'hold' stalled cycles.
    task automatic run_op(input logic [3:0] sel, input logic [7:0] a, input logic [7:0] b,
                          input bit clr_in_issue, input int hold);
        logic [11:0] e;
        logic [7:0]  res_s;
        logic [3:0]  flg_s;
        wait_ready();
        cmd_sel = sel; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        sb_q.push_back(model(sel, a, b));
        clr_sticky = clr_in_issue;
        check("issue_alu_a", 32'(alu_a), 32'(a));
        check("issue_alu_b", 32'(alu_b), 32'(b));
        check("issue_alu_sel", 32'(alu_sel), 32'(sel));
        check("issue_rsp_valid", 32'(rsp_valid), 32'd0);
        check("issue_cmd_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk);
        #1 clr_sticky = 1'b0;
        e = sb_q[sb_q.size() - 1];
        exp_sticky = (clr_in_issue ? 4'h0 : exp_sticky) | e[3:0];
        check("resp_valid_n2", 32'(rsp_valid), 32'd1);
        check("sticky", 32'(sticky_flags), 32'(exp_sticky));
        res_s = rsp_result;
        flg_s = rsp_flags;
        for (int i = 0; i < hold; i++) begin
            cmd_valid = i[0];
            cmd_a = 8'($urandom);
            cmd_b = 8'($urandom);
            cmd_sel = 4'($urandom);
            @(posedge clk);
            #1;
            check("stall_valid", 32'(rsp_valid), 32'd1);
            check("stall_result", 32'(rsp_result), 32'(res_s));
            check("stall_flags", 32'(rsp_flags), 32'(flg_s));
            check("stall_cmd_ready", 32'(cmd_ready), 32'd0);
            check("stall_alu", {12'h0, alu_sel, alu_a, alu_b}, {12'h0, sel, a, b});
            check("stall_count", 32'(op_count), 32'(exp_count));
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        e = sb_q.pop_front();
        check("rsp_result", 32'(rsp_result), 32'(e[11:4]));
        check("rsp_flags", 32'(rsp_flags), 32'(e[3:0]));
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        exp_count = exp_count + 16'd1;
        check("op_count", 32'(op_count), 32'(exp_count));
        check("post_rsp_valid", 32'(rsp_valid), 32'd0);
        check("post_cmd_ready", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        logic [3:0] sels [5];
        sels = '{4'b0000, 4'b0001, 4'b0100, 4'b0101, 4'b0110};

        // Reset values
        do_reset(2);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp", {20'h0, rsp_result, rsp_flags}, 32'd0);
        check("rst_sticky", 32'(sticky_flags), 32'd0);
        check("rst_count", 32'(op_count), 32'd0);
        check("rst_alu", {12'h0, alu_sel, alu_a, alu_b}, 32'd0);

        // Reset while a response is pending: discarded, not counted
        cmd_sel = 4'b0000; cmd_a = 8'h7F; cmd_b = 8'h01; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(posedge clk);
        #1 check("pre_rst_rsp_valid", 32'(rsp_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_count", 32'(op_count), 32'd0);
        check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("midrst_sticky", 32'(sticky_flags), 32'd0);
        check("midrst_alu_a", 32'(alu_a), 32'd0);

        // SUB borrow, then sticky clear in IDLE
        run_op(4'b0001, 8'h00, 8'h01, 1'b0, 0);
        check("sub_sticky", 32'(sticky_flags), 32'h5);
        clr_sticky = 1'b1;
        @(posedge clk);
        #1 clr_sticky = 1'b0;
        exp_sticky = 4'h0;
        check("clr_sticky", 32'(sticky_flags), 32'h0);

        // ADD overflow, logic op carry masking, backpressure
        run_op(4'b0000, 8'h7F, 8'h01, 1'b0, 0);
        run_op(4'b0100, 8'h0F, 8'hF0, 1'b0, 0);
        run_op(4'b0001, 8'h80, 8'h01, 1'b0, 5);

        // Clear colliding with capture
        clr_sticky = 1'b1;
        @(posedge clk);
        #1 clr_sticky = 1'b0;
        exp_sticky = 4'h0;
        run_op(4'b0000, 8'hFF, 8'h01, 1'b1, 0);
        check("collide_sticky", 32'(sticky_flags), 32'h3);

        // Random mix
        for (int k = 0; k < 8; k++) begin
            run_op(sels[$urandom_range(0, 4)], 8'($urandom), 8'($urandom), 1'b0, int'($urandom_range(0, 2)));
        end
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Sequential front end for the 8-bit combinational ALU. It accepts operation commands over a valid/ready handshake, drives the ALU operand and select inputs from registers, and captures the ALU outputs one cycle later. It returns each result with qualified flags over a second valid/ready handshake, and maintains sticky status flags and a completed-operation counter. It sits between a command source (test sequencer or micro-controller) and the ALU, and is the only block that drives the ALU inputs.

## Interface
- No parameters; data width fixed at 8, select width 4, counter width 16.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: sequencer can accept a command.
- `cmd_sel` input 4: ALU operation code.
- `cmd_a` input 8: operand A.
- `cmd_b` input 8: operand B.
- `alu_a` output 8: registered operand A to the ALU.
- `alu_b` output 8: registered operand B to the ALU.
- `alu_sel` output 4: registered select to the ALU.
- `alu_result` input 8: ALU result.
- `alu_carry` input 1: ALU carry.
- `alu_zero` input 1: ALU zero flag.
- `alu_negative` input 1: ALU negative flag.
- `rsp_valid` output 1: response present.
- `rsp_ready` input 1: consumer accepts the response.
- `rsp_result` output 8: captured result.
- `rsp_flags` output 4: {overflow, negative, zero, carry}.
- `sticky_flags` output 4: OR-accumulated rsp_flags, same bit order.
- `clr_sticky` input 1: single-cycle clear of sticky_flags.
- `op_count` output 16: number of completed response handshakes.

## Operation
- The FSM has three states: IDLE, ISSUE, RESP. The reset state is IDLE.
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid`&&`cmd_ready`: latch `cmd_a`/`cmd_b`/`cmd_sel` into `alu_a`/`alu_b`/`alu_sel`, then go to ISSUE.
- **ISSUE**
  - `cmd_ready`=0. The ALU settles combinationally.
  - At the end of the cycle:
    - `rsp_result` <= `alu_result`.
    - `rsp_flags` are captured as listed below.
    - `rsp_valid` <= 1, then go to RESP.
- **RESP**
  - `rsp_valid`=1; all `rsp_*` outputs are held stable.
  - On `rsp_ready`:
    - `rsp_valid` <= 0.
    - `op_count` += 1, wrapping 0xFFFF -> 0x0000.
    - Go to IDLE.
- **Flag qualification at capture**
  - carry = `alu_carry` when `alu_sel[3:2]`==2'b00; otherwise 0.
  - zero = `alu_zero`.
  - negative = `alu_negative`.
  - overflow is computed locally from `alu_a`, `alu_b` and `alu_result`:
    - sel 0000 (ADD): (a[7]==b[7]) && (r[7]!=a[7]).
    - sel 0001 (SUB): (a[7]!=b[7]) && (r[7]!=a[7]).
    - All other codes: 0.
- **Sticky flags**
  - On each capture, `sticky_flags` <= `sticky_flags` | new `rsp_flags`.
  - `clr_sticky` clears `sticky_flags` to 0.
  - If `clr_sticky` and a capture occur in the same cycle, `sticky_flags` <= new `rsp_flags` (capture wins over the cleared value).
- `alu_a`/`alu_b`/`alu_sel` hold their last values outside ISSUE. They change only on command acceptance.
- `cmd_valid` in ISSUE or RESP is ignored; commands are never dropped or partially latched.

## Timing
- **Reset values:** `cmd_ready`=1, `rsp_valid`=0, `rsp_result`=0x00, `rsp_flags`=0, `sticky_flags`=0, `op_count`=0, `alu_a`=0x00, `alu_b`=0x00, `alu_sel`=4'b0000.
- **Latency**
  - Acceptance edge at cycle N.
  - ALU inputs valid during N+1.
  - `rsp_valid`=1 from N+2.
- **Throughput:** at most one command per 3 cycles when `rsp_ready` is held high.
- `cmd_ready` is a registered state decode; it has no combinational path from `rsp_ready`.
- **Backpressure:** with `rsp_ready` low, RESP holds indefinitely, and `cmd_ready` stays 0 for the whole stall.
- **Reset mid-operation** (ISSUE or RESP): the next cycle is IDLE with all reset values. The pending response is discarded and is not counted.
- The ALU must be combinational; the sequencer samples it exactly one cycle after driving it.

## Test plan
- **Reset state:** assert `rst` for 2 cycles -> all outputs at the reset values listed above; `cmd_ready`=1.
- **ADD overflow:** sel=0000, A=0x7F, B=0x01, `rsp_ready`=1 -> `rsp_valid` at N+2; `rsp_result`=0x80; `rsp_flags`=4'b1100 (ovf=1, neg=1); `op_count`=1 after the handshake.
- **SUB borrow, then sticky clear:**
  - Stimulus: sel=0001, A=0x00, B=0x01.
  - Expected response: result=0xFF, `rsp_flags`=4'b0101 (neg=1, carry=1), `sticky_flags`=4'b0101.
  - Then pulse `clr_sticky` in IDLE -> `sticky_flags`=0.
- **Carry masked on logic op:** sel=0100, A=0x0F, B=0xF0 -> result=0x00, `rsp_flags`=4'b0010 (zero only).
- **Backpressure:**
  - Stimulus: hold `rsp_ready`=0 for 5 cycles in RESP while toggling `cmd_valid` with new operands.
  - Expected: `rsp_*` stable, `cmd_ready`=0, `alu_*` unchanged.
  - On release: exactly one handshake occurs and `op_count` increments by 1.
- **Reset during RESP, and clear/capture collision:**
  - Assert `rst` while `rsp_valid`=1 -> `rsp_valid`=0 next cycle, `op_count` unchanged at 0.
  - Separately, assert `clr_sticky` in the ISSUE cycle of an ADD 0xFF+0x01 -> `sticky_flags`=4'b0011.
